hazard_nop_unit: RTL and testbench
==================================

// Module: hazard_nop_unit
// PURPOSE
//  Pipeline hazard sequencer feeding the NOP input of the LEGLite decode-stage Control block.
//  - Watches the instruction in IF/ID and the load in ID/EX.
//  - Watches the branch outcome resolved in EX/MEM.
//  - Drives nop (bubble insertion), pc_write and ifid_write (stall), and ifid_flush (squash).
//  - Counts stall and flush cycles for performance debug.
// PARAMETERS
//  LU_STALL     1   bubbles inserted per load-use hazard (1..3)
//  FLUSH_CYCLES 2   bubbles inserted after a taken CBZ (1..3)
//  CNT_W        16  width of saturating stall/flush counters
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      synchronous, active-low reset
//  ifid_opcode    in   3      opcode of the instruction in ID
//  ifid_rn        in   3      Rn field of the ID instruction
//  ifid_rm        in   3      Rm field of the ID instruction
//  ifid_rt        in   3      Rt field of the ID instruction
//  idex_memread   in   1      instruction in EX is LD
//  idex_rd        in   3      destination register of the instruction in EX
//  branch_taken   in   1      CBZ in MEM resolved taken (1-cycle pulse)
//  nop            out  1      to Control NOP; 1 forces all control signals to 0
//  pc_write       out  1      1 = PC may update
//  ifid_write     out  1      1 = IF/ID may load
//  ifid_flush     out  1      1 = IF/ID loads a bubble
//  stall_cnt      out  CNT_W  total load-use stall cycles, saturating
//  flush_cnt      out  CNT_W  total flush cycles, saturating
// BEHAVIOUR
//  Source-use decode (combinational, from ifid_opcode):
//  - rs1 = Rn is used by opcodes 0,1,3,4,6,7.
//  - rs2 = Rm is used by opcodes 0,1. rs2 = Rt is used by opcodes 4,5.
//  - Opcode 2 is undefined: it uses no sources, and nop=1 whenever it sits in ID.
//  - hazard = idex_memread & ((rs1 used & ifid_rn==idex_rd) | (rs2 used & rs2==idex_rd)).
//  FSM states: RUN, STALL, FLUSH. The 2-bit down-counter cnt is used in STALL and FLUSH.
//  RUN:
//  - If branch_taken: ifid_flush=1, nop=1, pc_write=1, ifid_write=1.
//    If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2.
//  - Else if hazard: nop=1, pc_write=0, ifid_write=0.
//    If LU_STALL>1, go to STALL with cnt=LU_STALL-2.
//  - Else: nop=0 (opcode 2 excepted), pc_write=1, ifid_write=1, ifid_flush=0.
//  - Detection is same-cycle (Mealy). The first bubble appears in the cycle the hazard or branch is seen.
//  STALL:
//  - Outputs nop=1, pc_write=0, ifid_write=0.
//  - Go to RUN when cnt==0, else decrement cnt.
//  - A branch_taken during STALL preempts the stall: enter the RUN branch action from the next cycle on.
//  FLUSH:
//  - Outputs nop=1, ifid_flush=1, pc_write=1, ifid_write=1.
//  - Go to RUN when cnt==0, else decrement cnt.
//  - hazard is ignored in FLUSH, because the ID instruction is squashed.
//  - A branch_taken in FLUSH restarts the flush with cnt=FLUSH_CYCLES-2.
//  Priority: branch_taken > hazard.
//  Counters:
//  - stall_cnt increments in every cycle where pc_write=0.
//  - flush_cnt increments in every cycle where ifid_flush=1.
//  - Both saturate at 2^CNT_W-1 and do not wrap.
//  Reset:
//  - While reset==0 at a clock edge: state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
//  - While reset==0 the outputs are forced: nop=1, pc_write=0, ifid_write=0, ifid_flush=1.
//  - Reset mid-STALL or mid-FLUSH aborts to RUN. There is no residual bubble after reset deasserts.
// TESTING
//  1. Reset low 2 cycles.
//     -> nop=1, pc_write=0, ifid_flush=1, counters 0.
//     After release with ADD in ID and no hazard -> nop=0, pc_write=1, ifid_write=1.
//  2. idex_memread=1, idex_rd=3; ID has ADD with rn=3, LU_STALL=1.
//     -> exactly 1 cycle with nop=1, pc_write=0, ifid_write=0. Then RUN. stall_cnt=1.
//  3. Same as 2 with ID = ADDI rn=2, rt=3, idex_rd=3.
//     -> no stall, because Rt is not a source of ADDI.
//     ST with rt=3 -> 1-cycle stall.
//  4. branch_taken pulse, FLUSH_CYCLES=2.
//     -> 2 consecutive cycles with ifid_flush=1, nop=1, pc_write=1. flush_cnt=2.
//  5. branch_taken and hazard in the same cycle.
//     -> flush path only (pc_write=1). stall_cnt unchanged.
//  6. LU_STALL=3, reset driven low in the 2nd stall cycle.
//     -> state RUN after release. Next hazard-free cycle has nop=0.
//     Also: opcode 2 in ID -> nop=1 with pc_write=1.

Source files
------------

// File: rtl/hazard_nop_unit.sv
// hazard_nop_unit: load-use stall and taken-branch flush sequencer driving the decode-stage NOP,
// with saturating stall/flush cycle counters.
module hazard_nop_unit #(
   parameter int LU_STALL     = 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic [2:0]       ifid_opcode_i,
   input  logic [2:0]       ifid_rn_i,
   input  logic [2:0]       ifid_rm_i,
   input  logic [2:0]       ifid_rt_i,
   input  logic             idex_memread_i,
   input  logic [2:0]       idex_rd_i,
   input  logic             branch_taken_i,
   output logic             nop_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);
   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;
   localparam logic [1:0] LU_INIT    = 2'(LU_STALL > 1 ? LU_STALL - 2 : 0);
   localparam logic [1:0] FL_INIT    = 2'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
   localparam logic [1:0] FL_PREEMPT = 2'(FLUSH_CYCLES - 1);
   state_e           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             rs1_use, rs2_use, hazard;
   logic [2:0]       rs2;
   assign rs1_use = !(ifid_opcode_i inside {3'd2, 3'd5});
   assign rs2_use = ifid_opcode_i inside {3'd0, 3'd1, 3'd4, 3'd5};
   assign rs2     = ifid_opcode_i[2] ? ifid_rt_i : ifid_rm_i;
   assign hazard  = idex_memread_i & ((rs1_use & (ifid_rn_i == idex_rd_i)) | (rs2_use & (rs2 == idex_rd_i)));
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      nop_o        = 1'b1;
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b0;
      case (state_q)
         RUN:
            if (branch_taken_i) begin
               ifid_flush_o = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  cnt_d   = FL_INIT;
               end
            end else if (hazard) begin
               pc_write_o   = 1'b0;
               ifid_write_o = 1'b0;
               if (LU_STALL > 1) begin
                  state_d = STALL;
                  cnt_d   = LU_INIT;
               end
            end else nop_o = ifid_opcode_i == 3'd2;
         STALL: begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            // a branch seen mid-stall becomes a full flush starting next cycle
            if (branch_taken_i) begin
               state_d = FLUSH;
               cnt_d   = FL_PREEMPT;
            end else if (cnt_q == 2'd0) state_d = RUN;
            else cnt_d = cnt_q - 2'd1;
         end
         FLUSH: begin
            ifid_flush_o = 1'b1;
            if (branch_taken_i) begin
               state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
               cnt_d   = FL_INIT;
            end else if (cnt_q == 2'd0) state_d = RUN;
            else cnt_d = cnt_q - 2'd1;
         end
         default: state_d = RUN;
      endcase
      if (!reset_i) begin
         nop_o        = 1'b1;
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         ifid_flush_o = 1'b1;
      end
   end
   assign stall_cnt_d = (!pc_write_o && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
   assign flush_cnt_d = (ifid_flush_o && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q     <= RUN;
         cnt_q       <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_nop_unit.sv
// tb_hazard_nop_unit: two parameterisations driven in lockstep, checked against a bubble-count model.
module tb_hazard_nop_unit;
   logic       clock_i = 1'b0;
   logic       reset_i;
   logic [2:0] op, rn, rm, rt, rd;
   logic       mr, bt;
   logic       nop_w[2], pc_w[2], ifw_w[2], fl_w[2];
   logic [15:0] sc0, fc0;
   logic [3:0]  sc1, fc1;
   int tests = 0, fails = 0;
   int lu[2] = '{1, 3};
   int fcy[2] = '{2, 3};
   int cmax[2] = '{65535, 15};
   int stall_left[2], flush_left[2], m_sc[2], m_fc[2];

   always #5 clock_i = ~clock_i;

   hazard_nop_unit #(.LU_STALL(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
      .clock_i(clock_i), .reset_i(reset_i), .ifid_opcode_i(op), .ifid_rn_i(rn), .ifid_rm_i(rm),
      .ifid_rt_i(rt), .idex_memread_i(mr), .idex_rd_i(rd), .branch_taken_i(bt),
      .nop_o(nop_w[0]), .pc_write_o(pc_w[0]), .ifid_write_o(ifw_w[0]), .ifid_flush_o(fl_w[0]),
      .stall_cnt_o(sc0), .flush_cnt_o(fc0));

   hazard_nop_unit #(.LU_STALL(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
      .clock_i(clock_i), .reset_i(reset_i), .ifid_opcode_i(op), .ifid_rn_i(rn), .ifid_rm_i(rm),
      .ifid_rt_i(rt), .idex_memread_i(mr), .idex_rd_i(rd), .branch_taken_i(bt),
      .nop_o(nop_w[1]), .pc_write_o(pc_w[1]), .ifid_write_o(ifw_w[1]), .ifid_flush_o(fl_w[1]),
      .stall_cnt_o(sc1), .flush_cnt_o(fc1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_hazard();
      logic [2:0] srcs[$];
      case (op)
         3'd0, 3'd1: begin srcs.push_back(rn); srcs.push_back(rm); end
         3'd3, 3'd6, 3'd7: srcs.push_back(rn);
         3'd4: begin srcs.push_back(rn); srcs.push_back(rt); end
         3'd5: srcs.push_back(rt);
         default: ;
      endcase
      if (!mr) return 1'b0;
      foreach (srcs[i]) if (srcs[i] == rd) return 1'b1;
      return 1'b0;
   endfunction

   // expected outputs as {nop, pc_write, ifid_write, ifid_flush}
   function automatic logic [3:0] model_out(input int k);
      if (!reset_i) return 4'b1001;
      if (flush_left[k] > 0) return 4'b1111;
      if (stall_left[k] > 0) return 4'b1000;
      if (bt) return 4'b1111;
      if (model_hazard()) return 4'b1000;
      return {op == 3'd2, 3'b110};
   endfunction

   task automatic drive(input logic [2:0] o, input logic [2:0] n, input logic [2:0] m, input logic [2:0] t,
                        input logic r, input logic [2:0] d, input logic b, input logic rs);
      op = o; rn = n; rm = m; rt = t; mr = r; rd = d; bt = b; reset_i = rs;
      #1;
   endtask

   task automatic idle();
      drive(3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
   endtask

   task automatic tick();
      logic [3:0] e;
      bit h;
      h = model_hazard();
      for (int k = 0; k < 2; k++) begin
         e = model_out(k);
         check($sformatf("dut%0d_nop", k), 32'(nop_w[k]), 32'(e[3]));
         check($sformatf("dut%0d_pc_write", k), 32'(pc_w[k]), 32'(e[2]));
         check($sformatf("dut%0d_ifid_write", k), 32'(ifw_w[k]), 32'(e[1]));
         check($sformatf("dut%0d_ifid_flush", k), 32'(fl_w[k]), 32'(e[0]));
         check($sformatf("dut%0d_stall_cnt", k), k == 0 ? 32'(sc0) : 32'(sc1), 32'(m_sc[k]));
         check($sformatf("dut%0d_flush_cnt", k), k == 0 ? 32'(fc0) : 32'(fc1), 32'(m_fc[k]));
         if (!reset_i) begin
            stall_left[k] = 0; flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
         end else begin
            if (!e[2] && m_sc[k] < cmax[k]) m_sc[k]++;
            if (e[0] && m_fc[k] < cmax[k]) m_fc[k]++;
            if (flush_left[k] > 0) flush_left[k] = bt ? fcy[k] - 1 : flush_left[k] - 1;
            else if (stall_left[k] > 0) begin
               if (bt) begin stall_left[k] = 0; flush_left[k] = fcy[k]; end
               else stall_left[k]--;
            end else if (bt) flush_left[k] = fcy[k] - 1;
            else if (h) stall_left[k] = lu[k] - 1;
         end
      end
      @(posedge clock_i);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         stall_left[k] = 0; flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end
      drive(3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      @(posedge clock_i);
      #1;
      check("rst_nop", 32'(nop_w[0]), 32'd1);
      check("rst_pc_write", 32'(pc_w[0]), 32'd0);
      check("rst_ifid_flush", 32'(fl_w[0]), 32'd1);
      tick();
      check("rst_stall_cnt", 32'(sc0), 32'd0);
      check("rst_flush_cnt", 32'(fc0), 32'd0);
      idle();
      check("run_nop", 32'(nop_w[0]), 32'd0);
      check("run_pc_write", 32'(pc_w[0]), 32'd1);
      check("run_ifid_write", 32'(ifw_w[0]), 32'd1);
      tick();
      drive(3'd0, 3'd3, 3'd1, 3'd0, 1'b1, 3'd3, 1'b0, 1'b1);
      check("lu_nop", 32'(nop_w[0]), 32'd1);
      check("lu_pc_write", 32'(pc_w[0]), 32'd0);
      check("lu_ifid_write", 32'(ifw_w[0]), 32'd0);
      tick();
      check("lu_stall_cnt", 32'(sc0), 32'd1);
      idle();
      check("lu_done_pc_write", 32'(pc_w[0]), 32'd1);
      check("lu_b_still_stalled", 32'(pc_w[1]), 32'd0);
      tick(); tick(); tick();
      drive(3'd3, 3'd2, 3'd1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b1);
      check("addi_rt_no_stall", 32'(pc_w[0]), 32'd1);
      tick();
      drive(3'd4, 3'd2, 3'd1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b1);
      check("st_rt_stall", 32'(pc_w[0]), 32'd0);
      tick();
      idle(); tick(); tick(); tick();
      drive(3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
      check("br_flush0", 32'(fl_w[0]), 32'd1);
      check("br_pc0", 32'(pc_w[0]), 32'd1);
      tick();
      idle();
      check("br_flush1", 32'(fl_w[0]), 32'd1);
      check("br_nop1", 32'(nop_w[0]), 32'd1);
      tick();
      check("br_flush_cnt", 32'(fc0), 32'd2);
      check("br_over", 32'(fl_w[0]), 32'd0);
      tick(); tick();
      drive(3'd0, 3'd3, 3'd1, 3'd0, 1'b1, 3'd3, 1'b1, 1'b1);
      check("br_haz_pc", 32'(pc_w[0]), 32'd1);
      tick();
      check("br_haz_stall_cnt", 32'(sc0), 32'd2);
      idle(); tick(); tick(); tick();
      drive(3'd0, 3'd3, 3'd1, 3'd0, 1'b1, 3'd3, 1'b0, 1'b1);
      tick();
      drive(3'd0, 3'd3, 3'd1, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0);
      check("rst_mid_stall_pc", 32'(pc_w[1]), 32'd0);
      tick();
      idle();
      check("after_rst_b_nop", 32'(nop_w[1]), 32'd0);
      check("after_rst_b_pc", 32'(pc_w[1]), 32'd1);
      tick();
      drive(3'd2, 3'd3, 3'd3, 3'd3, 1'b1, 3'd3, 1'b0, 1'b1);
      check("undef_nop", 32'(nop_w[0]), 32'd1);
      check("undef_pc", 32'(pc_w[0]), 32'd1);
      tick();
      drive(3'd4, 3'd5, 3'd0, 3'd6, 1'b1, 3'd6, 1'b0, 1'b1);
      tick();
      drive(3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
      check("br_in_stall_pc", 32'(pc_w[1]), 32'd0);
      tick();
      idle();
      check("br_in_stall_flush", 32'(fl_w[1]), 32'd1);
      tick(); tick(); tick(); tick();
      for (int i = 0; i < 600; i++) begin
         drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
               3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
               $urandom_range(0, 5) == 0, $urandom_range(0, 31) != 0);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
